// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point arithmetic library.
// Holds the result-class enum and the guard/round/sticky bit layout.
package fpu_pkg;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } states;

  // Extra bits below the mantissa LSB: guard, round, sticky.
  localparam int unsigned GRS_W = 3;
  localparam int unsigned G_OFS = 2;
  localparam int unsigned R_OFS = 1;
  localparam int unsigned S_OFS = 0;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// An all-zero input reports WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]           in_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Scan from the LSB upwards so the highest set bit writes last.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        cnt_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Five-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// Inputs are captured, then unpacked, aligned, added, normalised and rounded.
module fp_add_pipe
  import fpu_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         arg_vld,
  output logic [W-1:0] result,
  output states        state,
  output logic         res_vld
);

  localparam int unsigned FW        = MAN_W + 1 + GRS_W;
  localparam int unsigned SW        = FW + 1;
  localparam int unsigned LZC_W     = $clog2(FW + 1);
  localparam int unsigned ALIGN_MAX = MAN_W + GRS_W;

  typedef logic signed [EXP_W+1:0] sexp_t;

  localparam sexp_t        SEXP_ONE  = sexp_t'(1);
  localparam sexp_t        SEXP_ZERO = sexp_t'(0);
  localparam sexp_t        EXP_INF   = sexp_t'((2 ** EXP_W) - 1);
  localparam logic [W-1:0] QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic         spec;
    states        spec_st;
    logic [W-1:0] spec_res;
  } spec_t;

  typedef struct packed {
    spec_t            sp;
    logic             sign;
    logic             esub;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] ey;
    logic [MAN_W:0]   mx;
    logic [MAN_W:0]   my;
  } s1_t;

  typedef struct packed {
    spec_t            sp;
    logic             sign;
    logic             esub;
    logic [EXP_W-1:0] ex;
    logic [FW-1:0]    xf;
    logic [FW-1:0]    yf;
  } s2_t;

  typedef struct packed {
    spec_t            sp;
    logic             sign;
    logic [EXP_W-1:0] ex;
    logic [SW-1:0]    sum;
  } s3_t;

  typedef struct packed {
    spec_t         sp;
    logic          sign;
    logic          zero;
    sexp_t         e;
    logic [FW-1:0] n;
  } s4_t;

  logic [5:0]   vld_q, vld_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         op_q, op_d;
  s1_t          s1_q, s1_d;
  s2_t          s2_q, s2_d;
  s3_t          s3_q, s3_d;
  s4_t          s4_q, s4_d;
  logic [W-1:0] result_q, result_d;
  states        state_q, state_d;

  // Stage 0: input capture
  always_comb begin
    vld_d = {vld_q[4:0], arg_vld};
    a_d   = arg_vld ? a  : a_q;
    b_d   = arg_vld ? b  : b_q;
    op_d  = arg_vld ? op : op_q;
  end

  // Stage 1: classify, detect specials, order operands so X >= Y
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge;
  logic [MAN_W:0]         ma, mb;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;

  always_comb begin
    sa     = a_q[W-1];
    sb     = b_q[W-1] ^ op_q;
    ea     = a_q[MAN_W +: EXP_W];
    eb     = b_q[MAN_W +: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    a_zero = ~|ea;
    b_zero = ~|eb;
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    // Subnormals flush to zero, so their mantissa is dropped before comparing.
    ma     = {~a_zero, fa & {MAN_W{~a_zero}}};
    mb     = {~b_zero, fb & {MAN_W{~b_zero}}};
    mag_a  = {ea, ma[MAN_W-1:0]};
    mag_b  = {eb, mb[MAN_W-1:0]};
    a_ge   = mag_a >= mag_b;

    s1_d = s1_q;
    if (vld_q[0]) begin
      s1_d.esub           = sa ^ sb;
      s1_d.sign           = a_ge ? sa : sb;
      s1_d.ex             = a_ge ? ea : eb;
      s1_d.ey             = a_ge ? eb : ea;
      s1_d.mx             = a_ge ? ma : mb;
      s1_d.my             = a_ge ? mb : ma;
      s1_d.sp.spec        = 1'b1;
      s1_d.sp.spec_st     = OK;
      s1_d.sp.spec_res    = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb))) begin
        s1_d.sp.spec_st  = NAN;
        s1_d.sp.spec_res = QNAN;
      end else if (a_inf || b_inf) begin
        s1_d.sp.spec_st  = INF;
        s1_d.sp.spec_res = {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
        s1_d.sp.spec_st  = NUL;
        s1_d.sp.spec_res = {sa & sb, {(W-1){1'b0}}};
      end else begin
        s1_d.sp.spec     = 1'b0;
      end
    end
  end

  // Stage 2: align Y to X, folding shifted-out bits into sticky
  logic [EXP_W-1:0] ediff;
  int unsigned      shamt;
  logic [2*FW-1:0]  wide;

  always_comb begin
    ediff = s1_q.ex - s1_q.ey;
    shamt = 32'(ediff);
    wide  = {s1_q.my, {GRS_W{1'b0}}, {FW{1'b0}}} >> shamt;

    s2_d = s2_q;
    if (vld_q[1]) begin
      s2_d.sp   = s1_q.sp;
      s2_d.sign = s1_q.sign;
      s2_d.esub = s1_q.esub;
      s2_d.ex   = s1_q.ex;
      s2_d.xf   = {s1_q.mx, {GRS_W{1'b0}}};
      if (shamt >= ALIGN_MAX) begin
        s2_d.yf = {{(FW-1){1'b0}}, |s1_q.my};
      end else begin
        s2_d.yf = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
      end
    end
  end

  // Stage 3: magnitude add or subtract; X >= Y keeps the difference non-negative
  always_comb begin
    s3_d = s3_q;
    if (vld_q[2]) begin
      s3_d.sp   = s2_q.sp;
      s3_d.sign = s2_q.sign;
      s3_d.ex   = s2_q.ex;
      s3_d.sum  = s2_q.esub ? ({1'b0, s2_q.xf} - {1'b0, s2_q.yf})
                            : ({1'b0, s2_q.xf} + {1'b0, s2_q.yf});
    end
  end

  // Stage 4: normalise
  logic [LZC_W-1:0] lzc;

  fp_lzc #(
    .WIDTH(FW)
  ) u_lzc (
    .in_i (s3_q.sum[FW-1:0]),
    .cnt_o(lzc)
  );

  always_comb begin
    s4_d = s4_q;
    if (vld_q[3]) begin
      s4_d.sp   = s3_q.sp;
      s4_d.sign = s3_q.sign;
      s4_d.zero = 1'b0;
      if (s3_q.sum[SW-1]) begin
        s4_d.n = {s3_q.sum[SW-1:2], s3_q.sum[1] | s3_q.sum[0]};
        s4_d.e = $signed({2'b00, s3_q.ex}) + SEXP_ONE;
      end else if (~|s3_q.sum[FW-1:0]) begin
        s4_d.zero = 1'b1;
        s4_d.n    = '0;
        s4_d.e    = SEXP_ZERO;
      end else begin
        s4_d.n = s3_q.sum[FW-1:0] << lzc;
        s4_d.e = $signed({2'b00, s3_q.ex}) - sexp_t'(lzc);
      end
    end
  end

  // Stage 5: round to nearest even, range check, special override
  logic             rnd_inc;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] man_r;
  sexp_t            e_r;

  always_comb begin
    rnd_inc = s4_q.n[G_OFS] & (s4_q.n[R_OFS] | s4_q.n[S_OFS] | s4_q.n[GRS_W]);
    mr      = {1'b0, s4_q.n[FW-1:GRS_W]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    man_r   = mr[MAN_W-1:0];
    e_r     = s4_q.e;
    if (mr[MAN_W+1]) begin
      man_r = mr[MAN_W:1];
      e_r   = s4_q.e + SEXP_ONE;
    end

    result_d = result_q;
    state_d  = state_q;
    if (vld_q[4]) begin
      if (s4_q.sp.spec) begin
        result_d = s4_q.sp.spec_res;
        state_d  = s4_q.sp.spec_st;
      end else if (s4_q.zero) begin
        result_d = '0;
        state_d  = NUL;
      end else if (e_r >= EXP_INF) begin
        result_d = {s4_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        state_d  = INF;
      end else if (e_r <= SEXP_ZERO) begin
        result_d = {s4_q.sign, {(W-1){1'b0}}};
        state_d  = NUL;
      end else begin
        result_d = {s4_q.sign, e_r[EXP_W-1:0], man_r};
        state_d  = OK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      s4_q     <= '0;
      result_q <= '0;
      state_q  <= OK;
    end else begin
      vld_q    <= vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      result_q <= result_d;
      state_q  <= state_d;
    end
  end

  assign result  = result_q;
  assign state   = state_q;
  assign res_vld = vld_q[5];

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe in FP32 and half-precision configurations.
// Each task drives its own scenario and checks results inline.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sp_a, sp_b, sp_res;
  logic        sp_op, sp_vld, sp_rv;
  logic [1:0]  sp_st;
  logic [15:0] hp_a, hp_b, hp_res;
  logic        hp_op, hp_vld, hp_rv;
  logic [1:0]  hp_st;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_add_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) u_sp (
    .clk    (clk),
    .rst    (rst),
    .a      (sp_a),
    .b      (sp_b),
    .op     (sp_op),
    .arg_vld(sp_vld),
    .result (sp_res),
    .state  (sp_st),
    .res_vld(sp_rv)
  );

  fp_add_pipe #(
    .EXP_W(5),
    .MAN_W(10)
  ) u_hp (
    .clk    (clk),
    .rst    (rst),
    .a      (hp_a),
    .b      (hp_b),
    .op     (hp_op),
    .arg_vld(hp_vld),
    .result (hp_res),
    .state  (hp_st),
    .res_vld(hp_rv)
  );

  // Stream table: 1+1, 2+1, 3-1, 4+4, 5-6, 8-1, 1+(-1), 3+6
  logic [31:0] vec_a [0:7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h41000000, 32'h3F800000, 32'h40400000};
  logic [31:0] vec_b [0:7] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000,
                               32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h40C00000};
  logic        vec_o [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] vec_r [0:7] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h41000000,
                               32'hBF800000, 32'h40E00000, 32'h00000000, 32'h41100000};
  logic [1:0]  vec_s [0:7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};

  task automatic drive_sp(input logic [31:0] x, input logic [31:0] y, input logic o,
                          output logic [31:0] r, output logic [1:0] s, output int lat);
    @(negedge clk);
    sp_a = x; sp_b = y; sp_op = o; sp_vld = 1'b1;
    @(negedge clk);
    sp_vld = 1'b0;
    r = '0; s = '0; lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (sp_rv === 1'b1) begin
        r = sp_res; s = sp_st; lat = k;
        break;
      end
    end
  endtask

  task automatic drive_hp(input logic [15:0] x, input logic [15:0] y, input logic o,
                          output logic [15:0] r, output logic [1:0] s, output int lat);
    @(negedge clk);
    hp_a = x; hp_b = y; hp_op = o; hp_vld = 1'b1;
    @(negedge clk);
    hp_vld = 1'b0;
    r = '0; s = '0; lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (hp_rv === 1'b1) begin
        r = hp_res; s = hp_st; lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (sp_res !== 32'h0 || sp_st !== 2'b00 || sp_rv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sp: got res=%h st=%b vld=%b want 00000000/00/0", sp_res, sp_st, sp_rv);
    end
    n_tests++;
    if (hp_res !== 16'h0 || hp_st !== 2'b00 || hp_rv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hp: got res=%h st=%b vld=%b want 0000/00/0", hp_res, hp_st, hp_rv);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    logic [1:0]  s;
    int          lat;
    drive_sp(32'h3F800000, 32'h40000000, 1'b0, r, s, lat);
    n_tests++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 5", lat);
    end
    n_tests++;
    if (r !== 32'h40400000 || s !== 2'b00) begin
      n_fail++; $display("FAIL basic_sum: got %h/%b want 40400000/00", r, s);
    end
    @(posedge clk); #1;
    n_tests++;
    if (sp_rv !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: got res_vld=%b want 0", sp_rv);
    end
    n_tests++;
    if (sp_res !== 32'h40400000 || sp_st !== 2'b00) begin
      n_fail++; $display("FAIL basic_hold: got %h/%b want 40400000/00", sp_res, sp_st);
    end
  endtask

  task automatic test_specials();
    logic [31:0] ta [0:9] = '{32'h7F800000, 32'h7F800000, 32'h7FC00001, 32'h7F800000,
                              32'h3F800000, 32'h80000000, 32'h80000000, 32'h3F800000,
                              32'h7F800000, 32'h00000000};
    logic [31:0] tb [0:9] = '{32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                              32'h3F800000, 32'h80000000, 32'h00000000, 32'hFF800000,
                              32'h7F800000, 32'h80000000};
    logic        to [0:9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] tr [0:9] = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                              32'h00000000, 32'h80000000, 32'h80000000, 32'h7F800000,
                              32'h7F800000, 32'h00000000};
    logic [1:0]  ts [0:9] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10,
                              2'b10, 2'b11};
    logic [31:0] r;
    logic [1:0]  s;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      drive_sp(ta[i], tb[i], to[i], r, s, lat);
      n_tests++;
      if (r !== tr[i] || s !== ts[i] || lat !== 5) begin
        n_fail++;
        $display("FAIL special_%0d: got %h/%b lat %0d want %h/%b lat 5", i, r, s, lat, tr[i], ts[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [0:6] = '{32'h7F7FFFFF, 32'h3F800000, 32'h3F800001, 32'h3F7FFFFF,
                              32'h3F7FFFFF, 32'h3F800000, 32'h00800000};
    logic [31:0] tb [0:6] = '{32'h7F7FFFFF, 32'h33800000, 32'h33800000, 32'h33800000,
                              32'h33000000, 32'h33800000, 32'h00800001};
    logic        to [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] tr [0:6] = '{32'h7F800000, 32'h3F800000, 32'h3F800002, 32'h3F800000,
                              32'h3F800000, 32'h3F7FFFFF, 32'h80000000};
    logic [1:0]  ts [0:6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [31:0] r;
    logic [1:0]  s;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      drive_sp(ta[i], tb[i], to[i], r, s, lat);
      n_tests++;
      if (r !== tr[i] || s !== ts[i]) begin
        n_fail++;
        $display("FAIL round_%0d: got %h/%b want %h/%b", i, r, s, tr[i], ts[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [15:0] ta [0:3] = '{16'h3C00, 16'h7BFF, 16'h3C00, 16'h7C01};
    logic [15:0] tb [0:3] = '{16'h3C00, 16'h7BFF, 16'h4000, 16'h0000};
    logic        to [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] tr [0:3] = '{16'h4000, 16'h7C00, 16'hBC00, 16'h7E00};
    logic [1:0]  ts [0:3] = '{2'b00, 2'b10, 2'b00, 2'b01};
    logic [15:0] r;
    logic [1:0]  s;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      drive_hp(ta[i], tb[i], to[i], r, s, lat);
      n_tests++;
      if (r !== tr[i] || s !== ts[i] || lat !== 5) begin
        n_fail++;
        $display("FAIL half_%0d: got %h/%b lat %0d want %h/%b lat 5", i, r, s, lat, tr[i], ts[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t < 8) begin
        sp_a = vec_a[t]; sp_b = vec_b[t]; sp_op = vec_o[t]; sp_vld = 1'b1;
      end else begin
        sp_vld = 1'b0;
      end
      @(posedge clk); #1;
      exp_v = (t >= 5 && t <= 12);
      n_tests++;
      if (sp_rv !== exp_v) begin
        n_fail++; $display("FAIL b2b_vld_t%0d: got %b want %b", t, sp_rv, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (sp_res !== vec_r[t-5] || sp_st !== vec_s[t-5]) begin
          n_fail++;
          $display("FAIL b2b_res_%0d: got %h/%b want %h/%b", t - 5, sp_res, sp_st,
                   vec_r[t-5], vec_s[t-5]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [7:0]  pat = 8'b1011_0010;
    logic        vh [0:13];
    logic [31:0] q_r [$];
    logic [1:0]  q_s [$];
    logic [31:0] er;
    logic [1:0]  es;
    logic        exp_v;
    int          idx = 0;
    for (int t = 0; t < 14; t++) vh[t] = 1'b0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t < 8 && pat[t]) begin
        sp_a = vec_a[idx]; sp_b = vec_b[idx]; sp_op = vec_o[idx]; sp_vld = 1'b1;
        q_r.push_back(vec_r[idx]);
        q_s.push_back(vec_s[idx]);
        idx++;
        vh[t] = 1'b1;
      end else begin
        sp_vld = 1'b0;
      end
      @(posedge clk); #1;
      exp_v = 1'b0;
      if (t >= 5) exp_v = vh[t-5];
      n_tests++;
      if (sp_rv !== exp_v) begin
        n_fail++; $display("FAIL gap_vld_t%0d: got %b want %b", t, sp_rv, exp_v);
      end
      if (exp_v) begin
        er = q_r.pop_front();
        es = q_s.pop_front();
        n_tests++;
        if (sp_res !== er || sp_st !== es) begin
          n_fail++; $display("FAIL gap_res_t%0d: got %h/%b want %h/%b", t, sp_res, sp_st, er, es);
        end
      end
    end
  endtask

  task automatic test_reset_stream();
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (t == 3) rst = 1'b0;
      if (t == 8) begin
        sp_vld = 1'b0;
        rst    = 1'b1;
      end else begin
        sp_a = vec_a[t]; sp_b = vec_b[t]; sp_op = vec_o[t]; sp_vld = 1'b1;
      end
      if (t >= 3 && t < 8) begin
        #1;
        n_tests++;
        if (sp_res !== 32'h0 || sp_st !== 2'b00 || sp_rv !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_t%0d: got %h/%b vld %b want 00000000/00 vld 0", t, sp_res,
                   sp_st, sp_rv);
        end
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (sp_rv !== 1'b0) begin
        n_fail++; $display("FAIL rst_drain_%0d: got res_vld=%b want 0", k, sp_rv);
      end
    end
    n_tests++;
    if (sp_res !== 32'h0 || sp_st !== 2'b00) begin
      n_fail++; $display("FAIL rst_after: got %h/%b want 00000000/00", sp_res, sp_st);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    sp_a = '0; sp_b = '0; sp_op = 1'b0; sp_vld = 1'b0;
    hp_a = '0; hp_b = '0; hp_op = 1'b0; hp_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_basic();
    test_specials();
    test_rounding();
    test_half();
    test_back_to_back();
    test_gaps();
    test_reset_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor for the arithmetic library. It accepts one operand pair per cycle with no stall path and produces a correctly rounded (round-to-nearest-even) sum or difference after a fixed latency. Result, status class and valid leave together. It replaces the fixed-FP32 adder wherever a different format or subtraction is required.

## Interface
- `EXP_W`, default 8: exponent width; must be ≥ 3.
- `MAN_W`, default 23: stored mantissa width, without the hidden bit; must be ≥ 2.
- Derived localparam `W = 1 + EXP_W + MAN_W`.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `a`  in  W: operand A as {sign, exp, man}.
- `b`  in  W: operand B, same format.
- `op`  in  1: 0 computes a+b; 1 computes a−b.
- `arg_vld`  in  1: the block samples `a`, `b` and `op` on every clock edge where this is high.
- `result`  out  W: packed result.
- `state`  out  2: result class, from the package enum: OK=00, NAN=01, INF=10, NUL=11.
- `res_vld`  out  1: one-cycle pulse per accepted input, aligned with `result` and `state`.

## Operation
- Classify inputs:
  - exp all ones with man≠0 is NaN.
  - exp all ones with man=0 is Inf.
  - exp=0 is zero. Subnormals are flushed to a signed zero.
- Effective subtract flag: `esub = sa ^ sb ^ op`. The sign of B is also inverted when `op`=1.
- Stage 1 (unpack/swap): compare {exp, man} as magnitudes and order the operands so that X ≥ Y. Result sign defaults to the sign of X.
- Stage 2 (align):
  - Shift Y's {1, man} right by `ex − ey` into an (MAN_W+4)-bit field: hidden bit, mantissa, guard, round, sticky.
  - Shifted-out bits OR into sticky.
  - If the shift is ≥ MAN_W+3, the field becomes sticky-only.
- Stage 3 (add): compute an (MAN_W+5)-bit sum or difference of X and the aligned Y.
- Stage 4 (normalise):
  - On carry-out, shift right 1 (preserving sticky) and exp+1.
  - Otherwise shift left by the leading-zero count and exp−lzc.
  - An all-zero difference produces an exact zero.
- Stage 5 (round/pack):
  - Round to nearest even: increment when G=1 and (R|S|lsb)=1.
  - A rounding carry renormalises and sets exp+1.
  - exp ≥ 2^EXP_W−1 gives ±Inf with `state`=INF.
  - exp ≤ 0 gives a signed zero with `state`=NUL.
- Special overrides, applied in priority order:
  1. Any NaN input, or Inf−Inf under `esub`, gives the canonical qNaN {0, all ones, 1, 0…0} with `state`=NAN.
  2. A single Inf, or two Infs with equal effective sign, gives that Inf with `state`=INF.
  3. Exact cancellation gives +0 with `state`=NUL. The one exception: when both operands are zero with effective sign negative, the result is −0.
- Any other nonzero finite result has `state`=OK.

## Timing
- Latency 5: inputs sampled at edge N appear on `result`/`state` with `res_vld`=1 after edge N+5.
- Throughput 1 per cycle. There is no back-pressure and no input ready signal.
- A valid bit travels with each stage.
  - Stage data registers load only when the incoming valid is 1.
  - The output registers hold their last value while `res_vld`=0.
- Reset (`rst`=0, asynchronous):
  - All stage valids clear.
  - `result`=0, `state`=OK (00), `res_vld`=0.
  - In-flight operations are discarded; none emerge after reset releases.
- The first input sampled on the first edge with `rst`=1 yields `res_vld` 5 edges later.
- Gaps in `arg_vld` produce identical gaps in `res_vld`, with ordering preserved.

## Structure
- Package `fpu_pkg`:
  - `states` enum (OK/NAN/INF/NUL).
  - Rounding-bit position constants (G/R/S offsets).
  - Per-stage record structs stay inside the module because they depend on the parameters.
- Sub-module `fp_lzc #(WIDTH)`: combinational leading-zero counter with `$clog2(WIDTH+1)`-bit output, used in stage 4.
- Per-stage valid chain is a plain register vector.
- Target size about 250 RTL lines.

## Test plan
- FP32: 3F800000 + 40000000, `op`=0 → 40400000, OK, `res_vld` exactly 5 cycles later.
- FP32: 3F800000 − 3F800000 (`op`=1) → 00000000, NUL.
- Specials:
  - 7F800000 + FF800000 → 7FC00000, NAN.
  - 7F800000 + 3F800000 → 7F800000, INF.
  - 7FC00001 + anything → 7FC00000, NAN.
- Overflow and rounding:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, INF.
  - 3F800000 + 33800000 (a tie) → 3F800000.
  - 3F800001 + 33800000 → 3F800002.
- Streaming: 8 back-to-back vectors, then `rst` low at cycle 3 of the stream → no `res_vld` afterwards; `result`=0 and `state`=00 during reset.
- Parameter set EXP_W=5, MAN_W=10: 3C00 + 3C00 → 4000, OK; 7BFF + 7BFF → 7C00, INF.
